// File: rtl/serial_frame_deserializer_pkg.sv
// Shared definitions for the serial frame link: state encoding, frame size and word order.
// FRAME_PARITY_EN adds the CHECK state that samples the trailing parity bit.
package serial_frame_deserializer_pkg;

    localparam int NUM_WORDS  = 4;

    // Word 0 is sent first (MSB end of the frame); serializer and deserializer both use this order
    localparam int WORD_SA_I  = 0;
    localparam int WORD_SA_Q  = 1;
    localparam int WORD_CML_I = 2;
    localparam int WORD_CML_Q = 3;

`ifdef FRAME_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    function automatic int frame_bits(input int acc_width);
        return NUM_WORDS * acc_width;
    endfunction

endpackage

// File: rtl/serial_frame_deserializer_if.sv
// Serial line in, four parallel accumulator words and status strobes out.
// The deserializer is the slave; the line driver / readout side is the master.
interface serial_frame_deserializer_if #(
    parameter int ACC_WIDTH = 16
);
    logic                 serialStart;
    logic                 serialIn;
    logic [ACC_WIDTH-1:0] outData_SA_I;
    logic [ACC_WIDTH-1:0] outData_SA_Q;
    logic [ACC_WIDTH-1:0] outData_CML_I;
    logic [ACC_WIDTH-1:0] outData_CML_Q;
    logic                 outValid;
    logic                 frameAbort;
    logic                 parityErr;
    logic                 busy;

    modport master (
        output serialStart, serialIn,
        input  outData_SA_I, outData_SA_Q, outData_CML_I, outData_CML_Q,
        input  outValid, frameAbort, parityErr, busy
    );

    modport slave (
        input  serialStart, serialIn,
        output outData_SA_I, outData_SA_Q, outData_CML_I, outData_CML_Q,
        output outValid, frameAbort, parityErr, busy
    );
endinterface

// File: rtl/serial_frame_deserializer_shift_capture.sv
// Shift register plus bit counter for the frame deserializer; load starts a frame at bit 1.
// frame_d is the register's next value, so the FSM can capture the frame on the edge of its last bit.
module serial_shift_capture #(
    parameter int FRAME_BITS = 64,
    parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  clear,
    input  logic                  bit_in,
    output logic [FRAME_BITS-1:0] frame_d,
    output logic [CNT_W-1:0]      count_q
);
    logic [FRAME_BITS-1:0] frame_q;
    logic [CNT_W-1:0]      count_d;

    always_comb begin
        frame_d = frame_q;
        count_d = count_q;
        if (clear) begin
            frame_d = '0;
            count_d = '0;
        end else if (load) begin
            frame_d = {{(FRAME_BITS-1){1'b0}}, bit_in};
            count_d = CNT_W'(1);
        end else if (shift) begin
            frame_d = {frame_q[FRAME_BITS-2:0], bit_in};
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            count_q <= '0;
        end else begin
            frame_q <= frame_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Frame FSM and output word registers of the serial frame deserializer.
// Define FRAME_PARITY_EN to expect and check a trailing even-parity bit after each frame.
module serial_frame_deserializer
    import serial_frame_deserializer_pkg::*;
#(
    parameter int ACC_WIDTH = 16
) (
    input logic                        clk,
    input logic                        reset,
    serial_frame_deserializer_if.slave bus
);
    localparam int FRAME_BITS = frame_bits(ACC_WIDTH);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  word_q [NUM_WORDS];
    logic [ACC_WIDTH-1:0]  word_d [NUM_WORDS];
    logic                  out_valid_q, out_valid_d;
    logic                  frame_abort_q, frame_abort_d;
    logic                  load, shift, clear, capture, last_bit;
    logic [FRAME_BITS-1:0] frame_d;
    logic [CNT_W-1:0]      count_q;
`ifdef FRAME_PARITY_EN
    logic                  parity_err_q, parity_err_d;
`endif

    serial_shift_capture #(
        .FRAME_BITS (FRAME_BITS),
        .CNT_W      (CNT_W)
    ) u_capture (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .clear   (clear),
        .bit_in  (bus.serialIn),
        .frame_d (frame_d),
        .count_q (count_q)
    );

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        out_valid_d   = 1'b0;
        frame_abort_d = 1'b0;
        load          = 1'b0;
        shift         = 1'b0;
        clear         = 1'b0;
        capture       = 1'b0;
        last_bit      = (count_q == CNT_W'(FRAME_BITS - 1));
`ifdef FRAME_PARITY_EN
        parity_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.serialStart) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    clear = 1'b1;
                end
            end
            ST_SHIFT: begin
                // A start mid-frame drops the partial frame; this cycle's bit is bit 1 of the new one
                if (bus.serialStart) begin
                    load          = 1'b1;
                    frame_abort_d = 1'b1;
                end else begin
                    shift = 1'b1;
                    if (last_bit) begin
`ifdef FRAME_PARITY_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_IDLE;
                        capture = 1'b1;
`endif
                    end
                end
            end
`ifdef FRAME_PARITY_EN
            ST_CHECK: begin
                if (bus.serialStart) begin
                    load          = 1'b1;
                    frame_abort_d = 1'b1;
                    state_d       = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                    if (^{frame_d, bus.serialIn}) begin
                        parity_err_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            out_valid_d = 1'b1;
            for (int w = 0; w < NUM_WORDS; w++) begin
                word_d[w] = frame_d[FRAME_BITS-1-w*ACC_WIDTH -: ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            for (int w = 0; w < NUM_WORDS; w++) begin
                word_q[w] <= '0;
            end
`ifdef FRAME_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            frame_abort_q <= frame_abort_d;
            word_q        <= word_d;
`ifdef FRAME_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign bus.outData_SA_I  = word_q[WORD_SA_I];
    assign bus.outData_SA_Q  = word_q[WORD_SA_Q];
    assign bus.outData_CML_I = word_q[WORD_CML_I];
    assign bus.outData_CML_Q = word_q[WORD_CML_Q];
    assign bus.outValid      = out_valid_q;
    assign bus.frameAbort    = frame_abort_q;
    assign bus.busy          = (state_q != ST_IDLE);
`ifdef FRAME_PARITY_EN
    assign bus.parityErr     = parity_err_q;
`else
    assign bus.parityErr     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer: vector table of frames plus hand-written
// reset, restart, idle-noise and (with FRAME_PARITY_EN) parity sequences, scored through a queue.
module tb_serial_frame_deserializer;

    localparam int ACC = 16;
    localparam int FB  = 4 * ACC;
`ifdef FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        logic [63:0] frame;
        int          dueCyc;
    } expect_t;

    typedef struct {
        logic [15:0] saI;
        logic [15:0] saQ;
        logic [15:0] cmlI;
        logic [15:0] cmlQ;
        int          gap;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    serial_frame_deserializer_if #(.ACC_WIDTH(ACC)) bus ();

    serial_frame_deserializer #(.ACC_WIDTH(ACC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          cmpCount      = 0;
    int          failCount     = 0;
    int          cyc           = 0;
    int          abortCount    = 0;
    int          lastAbortCyc  = -1;
    int          parityCount   = 0;
    int          lastParityCyc = -1;
    int          frameStartCyc = 0;
    logic [63:0] abortSnap     = '0;
    expect_t     sb[$];
    int          validCycQ[$];
    expect_t     popE;

    // Cycle index advances on every active edge; everything else samples on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] outWords();
        return {bus.outData_SA_I, bus.outData_SA_Q, bus.outData_CML_I, bus.outData_CML_Q};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every outValid must match the oldest queued frame, at its due cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.outValid === 1'b1) begin
                validCycQ.push_back(cyc);
                if (sb.size() == 0) begin
                    cmpCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_outValid: got pulse at cycle %0d, required none", cyc);
                end else begin
                    popE = sb.pop_front();
                    checkOutput("frame_words", outWords(), popE.frame);
                    checkOutput("valid_latency", 64'(cyc), 64'(popE.dueCyc));
                end
            end
            if (bus.frameAbort === 1'b1) begin
                abortCount++;
                lastAbortCyc = cyc;
                abortSnap    = outWords();
            end
            if (bus.parityErr === 1'b1) begin
                parityCount++;
                lastParityCyc = cyc;
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.serialStart = 1'b0;
            bus.serialIn    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic sendPartial(input logic [63:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.serialStart = (i == 0);
            bus.serialIn    = frame[63-i];
        end
    endtask

    // Drives one whole frame MSB first; queues the expected result when a capture is due
    task automatic applyStimulus(input logic [63:0] frame, input logic flipParity, input logic expectValid);
        expect_t e;
        @(negedge clk);
        frameStartCyc   = cyc;
        bus.serialStart = 1'b1;
        bus.serialIn    = frame[63];
        if (expectValid && !flipParity) begin
            e.frame  = frame;
            e.dueCyc = cyc + FB + PAR;
            sb.push_back(e);
        end
        for (int i = 1; i < FB; i++) begin
            @(negedge clk);
            bus.serialStart = 1'b0;
            bus.serialIn    = frame[63-i];
        end
`ifdef FRAME_PARITY_EN
        @(negedge clk);
        bus.serialStart = 1'b0;
        bus.serialIn    = (^frame) ^ flipParity;
`endif
    endtask

    initial begin
        vec_t        vecs[3];
        logic [63:0] prevFrame;
        int          vc;
        int          ac;
        int          pc;
        int          busyHigh;

        vecs[0] = '{saI:16'h1234, saQ:16'hABCD, cmlI:16'h0001, cmlQ:16'hFFFF, gap:2};
        vecs[1] = '{saI:16'h0000, saQ:16'h8000, cmlI:16'h7FFF, cmlQ:16'h5555, gap:0};
        vecs[2] = '{saI:16'hDEAD, saQ:16'hBEEF, cmlI:16'hC0DE, cmlQ:16'h0F0F, gap:3};

        bus.serialStart = 1'b0;
        bus.serialIn    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset_words", outWords(), 64'h0);
        checkOutput("reset_valid", 64'(bus.outValid), 64'h0);
        checkOutput("reset_busy", 64'(bus.busy), 64'h0);
        checkOutput("reset_abort", 64'(bus.frameAbort), 64'h0);
        checkOutput("reset_parity", 64'(bus.parityErr), 64'h0);
        reset = 1'b0;
        idleCycles(2);

        // Reset at bit 20 discards the partial frame silently
        sendPartial(64'h1234ABCD0001FFFF, 20);
        @(negedge clk);
        bus.serialStart = 1'b0;
        bus.serialIn    = 1'b1;
        checkOutput("busy_midframe", 64'(bus.busy), 64'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_busy", 64'(bus.busy), 64'h0);
        checkOutput("midreset_words", outWords(), 64'h0);
        checkOutput("midreset_valid", 64'(bus.outValid), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idleCycles(2);

        // Frame table, including a back-to-back pair
        for (int i = 0; i < 3; i++) begin
            idleCycles(vecs[i].gap);
            applyStimulus({vecs[i].saI, vecs[i].saQ, vecs[i].cmlI, vecs[i].cmlQ}, 1'b0, 1'b1);
        end
        idleCycles(3);
        checkOutput("table_valid_count", 64'(validCycQ.size()), 64'd3);
        if (validCycQ.size() >= 2) begin
            checkOutput("btb_spacing", 64'(validCycQ[1] - validCycQ[0]), 64'(FB + PAR));
        end else begin
            cmpCount++;
            failCount++;
            $display("[TB] FAIL btb_spacing: got %0d pulses, required at least 2", validCycQ.size());
        end
        checkOutput("table_sb_drained", 64'(sb.size()), 64'd0);
        checkOutput("table_no_abort", 64'(abortCount), 64'd0);

        // Restart at bit 30, then a complete 0xAAAA frame
        prevFrame = {vecs[2].saI, vecs[2].saQ, vecs[2].cmlI, vecs[2].cmlQ};
        sendPartial(64'h5A5A_1234_9876_0F0F, 29);
        applyStimulus({4{16'hAAAA}}, 1'b0, 1'b1);
        checkOutput("restart30_abort_count", 64'(abortCount), 64'd1);
        checkOutput("restart30_abort_cycle", 64'(lastAbortCyc), 64'(frameStartCyc + 1));
        checkOutput("restart30_words_held", abortSnap, prevFrame);
        idleCycles(2);

        // Restart on the cycle where the last payload bit is expected
        sendPartial(64'hFEDC_BA98_7654_3210, FB - 1);
        applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        checkOutput("restart64_abort_count", 64'(abortCount), 64'd2);
        checkOutput("restart64_abort_cycle", 64'(lastAbortCyc), 64'(frameStartCyc + 1));
        checkOutput("restart64_words_held", abortSnap, {4{16'hAAAA}});
        idleCycles(3);
        checkOutput("restart_sb_drained", 64'(sb.size()), 64'd0);

        // Idle noise must be ignored entirely
        vc       = validCycQ.size();
        ac       = abortCount;
        busyHigh = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.serialStart = 1'b0;
            bus.serialIn    = i[0];
            if (bus.busy === 1'b1) busyHigh++;
        end
        @(negedge clk);
        checkOutput("idle_busy_cycles", 64'(busyHigh), 64'd0);
        checkOutput("idle_valid_count", 64'(validCycQ.size()), 64'(vc));
        checkOutput("idle_abort_count", 64'(abortCount), 64'(ac));
        checkOutput("idle_words_held", outWords(), 64'h0123_4567_89AB_CDEF);

`ifdef FRAME_PARITY_EN
        // Good parity captures; bad parity flags an error and leaves the words alone
        applyStimulus(64'h1234ABCD0001FFFF, 1'b0, 1'b1);
        idleCycles(2);
        checkOutput("parity_good_drained", 64'(sb.size()), 64'd0);
        pc = parityCount;
        applyStimulus(64'h1234ABCD0001FFFF, 1'b1, 1'b1);
        idleCycles(2);
        checkOutput("parity_bad_count", 64'(parityCount), 64'(pc + 1));
        checkOutput("parity_bad_cycle", 64'(lastParityCyc), 64'(frameStartCyc + FB + 1));
        applyStimulus(64'hDEAD_BEEF_C0DE_0F0F, 1'b1, 1'b1);
        idleCycles(2);
        checkOutput("parity_bad2_count", 64'(parityCount), 64'(pc + 2));
        checkOutput("parity_bad_words_held", outWords(), 64'h1234ABCD0001FFFF);
`else
        pc = parityCount;
        checkOutput("parity_never", 64'(pc), 64'd0);
`endif

        idleCycles(3);
        checkOutput("final_sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
- Receive-side stage that consumes the serialStart/serialOut stream produced by the accumulator serializer.
- Reassembles each frame into four parallel ACC_WIDTH accumulator words: SA_I, SA_Q, CML_I and CML_Q.
- Presents the words with a one-cycle valid strobe to the capture/readout logic.
- Runs on the serial clock domain; the line is sampled on every rising clk edge.

Parameters:
- ACC_WIDTH, 16, width of each accumulator word; frame payload FRAME_BITS = 4*ACC_WIDTH.

Ports:
- clk  input  1  serial-domain clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- serialStart  input  1  one-cycle frame-start marker, coincident with the first payload bit.
- serialIn  input  1  serial data, MSB first.
- outData_SA_I  output  ACC_WIDTH  frame bits [FRAME_BITS-1 : 3*ACC_WIDTH].
- outData_SA_Q  output  ACC_WIDTH  next ACC_WIDTH bits.
- outData_CML_I  output  ACC_WIDTH  next ACC_WIDTH bits.
- outData_CML_Q  output  ACC_WIDTH  last ACC_WIDTH bits.
- outValid  output  1  one-cycle pulse; the four words are valid and held until the next outValid.
- frameAbort  output  1  one-cycle pulse; frame restarted before completion.
- parityErr  output  1  one-cycle pulse; parity mismatch (optional feature only).
- busy  output  1  high while a frame is being shifted in.

Behaviour:
- Reset: all outputs 0, shift register 0, bit counter 0, state IDLE. Reset mid-frame discards the partial frame with no pulses.
- FSM states: IDLE, SHIFT, CHECK (CHECK exists only with FRAME_PARITY_EN).
- IDLE:
  - serialStart=1: load serialIn into the shift register LSB, counter=1, go to SHIFT.
  - serialStart=0: line ignored.
- SHIFT:
  - Each cycle: shift left, insert serialIn at the LSB, counter+1.
  - After bit FRAME_BITS is sampled (counter reaches FRAME_BITS), the next state is CHECK if the feature is enabled, otherwise IDLE with output update.
- Output update:
  - Register the split shift-register contents into the four out words.
  - outValid=1 for exactly one cycle, in the cycle after the last payload bit is sampled (latency 1 clk from last bit).
- Abort/restart: serialStart=1 while in SHIFT (including on the cycle where bit FRAME_BITS is expected):
  - Partial frame dropped and frameAbort pulses one cycle.
  - That cycle's bit becomes bit 1 of a new frame; counter=1, state stays SHIFT.
  - Out words are unchanged and outValid stays 0.
- Back-to-back frames: a serialStart in the cycle immediately after the last bit (state IDLE or CHECK) starts a new frame with no gap and no abort.
- busy: 1 in SHIFT and CHECK, 0 in IDLE.
- Counter width: $clog2(FRAME_BITS+1). Counter saturation cannot occur; it resets on each start.
- Output words are held between updates and never cleared except by reset.

Optional Feature:
- Macro: FRAME_PARITY_EN.
- Defined:
  - Frame carries one extra even-parity bit after the FRAME_BITS payload, covering all payload bits.
  - CHECK samples it.
  - Match: outValid pulses and the words update.
  - Mismatch: parityErr pulses, the words are unchanged, outValid stays 0.
  - serialStart during CHECK is treated as an abort (frameAbort pulses) and a new frame start.
- Not defined: no CHECK state; parityErr tied 0; frame length exactly FRAME_BITS.

Decomposition:
- Shared package/include:
  - State encodings IDLE/SHIFT/CHECK.
  - FRAME_BITS derivation.
  - Word order constants (SA_I first, CML_Q last), so the serializer and deserializer agree.
- One natural sub-module: serial_shift_capture, the shift register plus bit counter with load/shift/clear controls.
- The FSM and output registers stay in the top.

Test Plan:
- Reset: assert reset mid-frame at bit 20 -> all outputs 0, no outValid; the next full frame is captured correctly.
- Single frame: ACC_WIDTH=16, words 0x1234/0xABCD/0x0001/0xFFFF sent MSB first -> outValid one cycle after bit 64; outputs equal those values.
- Back-to-back: two frames with no gap (second 0x0000/0x8000/0x7FFF/0x5555) -> two outValid pulses exactly 64 cycles apart; second values correct; frameAbort never asserts.
- Restart: serialStart reasserted at bit 30, then a full frame 0xAAAA x4 -> frameAbort pulse at bit 30; single outValid with 0xAAAA x4; prior words held until then.
- Idle noise: toggle serialIn with serialStart=0 for 200 cycles -> busy=0, no pulses, outputs unchanged.
- FRAME_PARITY_EN: frame 0x1234/0xABCD/0x0001/0xFFFF with correct parity -> outValid; same frame with parity bit flipped -> parityErr pulse, outValid=0, words unchanged.
